// File: rtl/mini_src_ctrl_seq_if.sv
// Register select/encode and datapath strobe bundle between the control sequencer and datapath.
// The sequencer drives through the master modport; the datapath and memory side uses the slave modport.
interface mini_src_ctrl_seq_if;
   logic [31:0] ir;
   logic        con_ff;
   logic        mem_done;
   logic        stop;
   logic        gra, grb, grc, rin, rout, BAout, Cout;
   logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, CONin, InPortout, OutPortin;
   logic        Read, Write;
   logic [3:0]  alu_op;
   logic        run;

   modport master (
      input  ir, con_ff, mem_done, stop,
      output gra, grb, grc, rin, rout, BAout, Cout,
             PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, CONin, InPortout, OutPortin,
             Read, Write, alu_op, run
   );

   modport slave (
      output ir, con_ff, mem_done, stop,
      input  gra, grb, grc, rin, rout, BAout, Cout,
             PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, CONin, InPortout, OutPortin,
             Read, Write, alu_op, run
   );
endinterface

// File: rtl/mini_src_ctrl_seq.sv
// Fetch/decode/execute sequencer: one state per cycle, add 6 / ld 8 / jr 4 / br 7 cycles with no memory wait.
// Memory states stall on mem_done only when MINI_SRC_MEM_WAIT_EN is defined; stop halts at instruction boundaries.
module mini_src_ctrl_seq (
   input  logic                  clock,
   input  logic                  reset_n,
   mini_src_ctrl_seq_if.master   bus
);
   typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED} state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state, state_nxt;
   logic       halt_lock, halt_lock_nxt;
   logic [4:0] op;
   logic       mem_ok;
   logic       is_alu_r, is_alu_i, is_mem;
   logic       last;
   logic [3:0] op_fn;

   assign op = bus.ir[31:27];

`ifdef MINI_SRC_MEM_WAIT_EN
   assign mem_ok = bus.mem_done;
`else
   logic mem_done_unused;
   assign mem_done_unused = bus.mem_done;
   assign mem_ok = 1'b1;
`endif

   assign is_alu_r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   assign is_alu_i = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
   assign is_mem   = (op == OP_LD) || (op == OP_ST);

   always_comb begin
      op_fn = 4'd0;
      case (op)
         OP_SUB:          op_fn = 4'd1;
         OP_AND, OP_ANDI: op_fn = 4'd2;
         OP_OR,  OP_ORI:  op_fn = 4'd3;
         default:         op_fn = 4'd0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RST;
         halt_lock <= 1'b0;
      end else begin
         state     <= state_nxt;
         halt_lock <= halt_lock_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      halt_lock_nxt = halt_lock;
      last          = 1'b0;
      bus.gra = 1'b0;  bus.grb = 1'b0;  bus.grc = 1'b0;  bus.rin = 1'b0;
      bus.rout = 1'b0; bus.BAout = 1'b0; bus.Cout = 1'b0;
      bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
      bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
      bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Zlowout = 1'b0; bus.CONin = 1'b0;
      bus.InPortout = 1'b0; bus.OutPortin = 1'b0;
      bus.Read = 1'b0; bus.Write = 1'b0;
      bus.alu_op = 4'd0;
      bus.run = (state != RST) && (state != HALTED);

      case (state)
         RST: state_nxt = T0;
         T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
            state_nxt = T1;
         end
         T1: begin
            bus.Read = 1'b1; bus.MDRin = 1'b1;
            if (mem_ok) state_nxt = T2;
         end
         T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
            state_nxt = T3;
         end
         T3: begin
            state_nxt = T4;
            if (is_alu_r || is_alu_i) begin
               bus.grb = 1'b1; bus.rout = 1'b1; bus.Yin = 1'b1;
            end else if (is_mem || op == OP_LDI) begin
               bus.grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end else if (op == OP_BR) begin
               bus.gra = 1'b1; bus.rout = 1'b1; bus.CONin = 1'b1;
            end else if (op == OP_JR) begin
               bus.gra = 1'b1; bus.rout = 1'b1; bus.PCin = 1'b1;
               last = 1'b1;
            end else if (op == OP_IN) begin
               bus.InPortout = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1;
               last = 1'b1;
            end else if (op == OP_OUT) begin
               bus.gra = 1'b1; bus.rout = 1'b1; bus.OutPortin = 1'b1;
               last = 1'b1;
            end else if (op == OP_HALT) begin
               state_nxt     = HALTED;
               halt_lock_nxt = 1'b1;
            end else begin
               last = 1'b1;
            end
         end
         T4: begin
            state_nxt = T5;
            if (is_alu_r) begin
               bus.grc = 1'b1; bus.rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op_fn;
            end else if (is_alu_i) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op_fn;
            end else if (is_mem || op == OP_LDI) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1;
            end else if (op == OP_BR) begin
               bus.PCout = 1'b1; bus.Yin = 1'b1;
            end else begin
               last = 1'b1;
            end
         end
         T5: begin
            if (is_alu_r || is_alu_i || op == OP_LDI) begin
               bus.Zlowout = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1;
               last = 1'b1;
            end else if (is_mem) begin
               bus.Zlowout = 1'b1; bus.MARin = 1'b1;
               state_nxt = T6;
            end else if (op == OP_BR) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1;
               state_nxt = T6;
            end else begin
               last = 1'b1;
            end
         end
         T6: begin
            if (op == OP_LD) begin
               bus.Read = 1'b1; bus.MDRin = 1'b1;
               if (mem_ok) state_nxt = T7;
            end else if (op == OP_ST) begin
               bus.gra = 1'b1; bus.rout = 1'b1; bus.MDRin = 1'b1;
               state_nxt = T7;
            end else begin
               // Branch commits the computed target only when the condition flop is set
               bus.Zlowout = (op == OP_BR) && bus.con_ff;
               bus.PCin    = (op == OP_BR) && bus.con_ff;
               last = 1'b1;
            end
         end
         T7: begin
            if (op == OP_LD) begin
               bus.MDRout = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1;
               last = 1'b1;
            end else if (op == OP_ST) begin
               bus.Write = 1'b1;
               last = mem_ok;
            end else begin
               last = 1'b1;
            end
         end
         HALTED: begin
            if (!halt_lock && !bus.stop) state_nxt = T0;
         end
         default: state_nxt = RST;
      endcase

      if (last) begin
         state_nxt     = bus.stop ? HALTED : T0;
         halt_lock_nxt = 1'b0;
      end
   end
endmodule

// File: doc/mini_src_ctrl_seq.md
# mini_src_ctrl_seq

Control sequencer for the register-transfer datapath. It is the initiating end of the register select/encode interface: it generates `gra`/`grb`/`grc`, `rin`/`rout`/`BAout`, `Cout`, and every other datapath strobe, step by step, from the opcode in `ir`. It sits between the instruction register and the datapath. It fetches, decodes and executes one instruction at a time, and waits on memory through a `mem_done` handshake.

## Interface
Parameters:
- none

Ports:
- `clock`  in  1  — single clock; all state changes on rising edge.
- `reset_n`  in  1  — reset, asynchronous and active-low.
- `ir`  in  32  — instruction register contents; opcode is `ir[31:27]`.
- `con_ff`  in  1  — branch condition flop output.
- `mem_done`  in  1  — memory completion for the current `Read`/`Write`.
- `stop`  in  1  — request to pause at the next instruction boundary.
- `gra`, `grb`, `grc`, `rin`, `rout`, `BAout`, `Cout`  out  1 each  — select/encode controls.
- `PCout`, `PCin`, `IncPC`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zin`, `Zlowout`, `CONin`, `InPortout`, `OutPortin`  out  1 each  — datapath strobes.
- `Read`, `Write`  out  1 each  — memory requests.
- `alu_op`  out  4  — ALU function: 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
- `run`  out  1  — high while sequencing.

## Operation
States: `RST`, `T0`–`T7`, `HALTED`. Outputs are a decode of the state register plus `ir[31:27]`. Every strobe not listed for a step is 0.

Fetch:
- `T0`: `PCout`, `MARin`, `IncPC`.
- `T1`: `Read`, `MDRin`.
- `T2`: `MDRout`, `IRin`.

Execute, starting at `T3`, by opcode:
- add 00011 / sub 00100 / and 00101 / or 00110:
  - T3: `grb`, `rout`, `Yin`.
  - T4: `grc`, `rout`, `Zin`, `alu_op` = op.
  - T5: `Zlowout`, `gra`, `rin`.
- addi 01100 / andi 01101 / ori 01110: same as the register forms, with T4 replaced by `Cout`, `Zin`, `alu_op`.
- ldi 00001:
  - T3: `grb`, `BAout`, `Yin`.
  - T4: `Cout`, ADD, `Zin`.
  - T5: `Zlowout`, `gra`, `rin`.
- ld 00000:
  - T3–T4: as ldi.
  - T5: `Zlowout`, `MARin`.
  - T6: `Read`, `MDRin`.
  - T7: `MDRout`, `gra`, `rin`.
- st 00010:
  - T3–T5: as ld.
  - T6: `gra`, `rout`, `MDRin`.
  - T7: `Write`.
- br 10010:
  - T3: `gra`, `rout`, `CONin`.
  - T4: `PCout`, `Yin`.
  - T5: `Cout`, ADD, `Zin`.
  - T6: `Zlowout` and `PCin` only if `con_ff` = 1.
- jr 10011 — T3: `gra`, `rout`, `PCin`.
- in 10101 — T3: `InPortout`, `gra`, `rin`.
- out 10110 — T3: `gra`, `rout`, `OutPortin`.
- nop 11010, and any unlisted opcode: T3 with no strobes.
- halt 11011: T3 → `HALTED`.

Sequencing and control:
- After an instruction's last step, the next state is `T0`. If `stop` = 1 at that edge, the next state is `HALTED` instead.
- `HALTED` reached via `stop` returns to `T0` on the first edge with `stop` = 0.
- `HALTED` reached via halt is left only by reset.
- `run` = 0 in `RST` and `HALTED`, 1 otherwise.

## Timing
- `reset_n` low forces `RST` immediately. All outputs are 0 in `RST`, including `alu_op` = 0.
- Reset asserted mid-instruction abandons the instruction without completing any further strobe.
- First rising edge with `reset_n` high: `RST` → `T0`.
- Memory states (fetch `T1`, ld `T6`, st `T7`):
  - Hold the state and keep `Read`/`Write` asserted while `mem_done` = 0.
  - Advance on the edge where `mem_done` = 1.
  - `mem_done` already high on entry gives a one-cycle step.
- All other states last exactly one cycle.
- Latency with zero memory wait:
  - add: 6 cycles.
  - ld: 8 cycles.
  - jr: 4 cycles.
  - br: 7 cycles, taken or not taken.
- `stop` is sampled only at instruction boundaries. A pulse that does not cover a boundary edge has no effect.

## Configuration
- `MINI_SRC_MEM_WAIT_EN` defined: the memory states wait on `mem_done` as described in Timing.
- `MINI_SRC_MEM_WAIT_EN` undefined: `mem_done` is ignored, and every memory state lasts exactly one cycle.

## Test plan
- Reset held low for 3 cycles → all outputs 0, `run` = 0. After release: `T0` asserts `PCout` = `MARin` = `IncPC` = 1.
- `ir` = 0x18918000 (add R1, R2, R3), `mem_done` tied 1:
  - T3: `grb`, `rout`, `Yin`.
  - T4: `grc`, `rout`, `Zin`, `alu_op` = 0.
  - T5: `gra`, `rin`, `Zlowout`.
  - Back in `T0` 6 cycles after the first `T0`.
- ld (opcode 00000) with `mem_done` low for 4 cycles in `T6` → `Read` = `MDRin` = 1 for 5 cycles, then T7 asserts `MDRout`, `gra`, `rin`.
- br with `con_ff` = 0, then repeated with `con_ff` = 1 → `PCin` stays 0 in T6 for the first run and is 1 in T6 for the second.
- `stop` = 1 during an add's T5 → next state `HALTED`, `run` = 0. Dropping `stop` → `T0` on the next edge.
- halt (11011) → `HALTED`. Toggling `stop` causes no exit. `reset_n` low → `RST`.
